flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer end of the ALU flag interface: captures N/Z/C/V from completing flag-setting ALU ops into an architectural flag register.
- Tracks flag-setting ops still in flight and evaluates 4-bit condition codes for conditional instructions and branches at issue.
- Stalls condition queries until the flags are final, with a same-cycle bypass for the last outstanding write.
- An epoch bit discards flag writes from squashed instructions after a pipeline flush.

Parameters:
PEND_W, 3, width of the in-flight flag-writer counter; max outstanding = 2^PEND_W-1
RESET_FLAGS, 4'b0000, reset value of {N,Z,C,V}

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
set_pend  in  1  issue stage dispatched a flag-setting ALU op this cycle
pend_full  out  1  counter at max; issue must not assert set_pend
flag_wr_valid  in  1  ALU op completing with flag update
flag_wr_epoch  in  1  epoch captured when that op issued
flag_in  in  4  {neg,zero,carry,overflow} from ALU
flush  in  1  squash all in-flight flag writers
epoch  out  1  current epoch, sampled by issue with set_pend
cond_valid  in  1  condition query valid
cond_code  in  4  condition to evaluate
cond_ready  out  1  query accepted this cycle when cond_valid && cond_ready
res_valid  out  1  registered result valid, one-cycle pulse
res_taken  out  1  condition true
flags_q  out  4  architectural flags {N,Z,C,V}
pend_cnt  out  PEND_W  outstanding flag writers
flag_err  out  1  one-cycle pulse: current-epoch write with pend_cnt==0

Behaviour:
- Reset, asynchronous on rst_n low:
  - flags_q=RESET_FLAGS, pend_cnt=0, epoch=0.
  - res_valid=0, res_taken=0, flag_err=0.
  - An in-flight query is dropped.
- Write acceptance:
  - wr_ok = flag_wr_valid && (flag_wr_epoch==epoch).
  - A stale-epoch write is ignored entirely: no flag change, no count change, no error.
- Flags register: on wr_ok, flags_q <= flag_in at the next edge.
- Counter update, next value:
  - flush: 0.
  - set_pend && !wr_ok: +1.
  - wr_ok && !set_pend && cnt>0: -1.
  - set_pend && wr_ok: unchanged.
  - Otherwise unchanged.
- Counter limits:
  - pend_full = (pend_cnt == 2^PEND_W-1), combinational.
  - set_pend while pend_full: counter saturates.
- Error case: wr_ok with pend_cnt==0 and no set_pend →
  - flags still updated;
  - count stays 0;
  - flag_err pulses next cycle.
- Flush:
  - epoch toggles; counter cleared; set_pend in the same cycle ignored.
  - wr_ok in the flush cycle (old epoch matches) still updates flags_q.
- Query handshake:
  - cond_ready = !flush && (pend_cnt==0 || (pend_cnt==1 && wr_ok && !set_pend)). Combinational from inputs and state.
  - Evaluation flags: flag_in when bypassing (pend_cnt==1 case), otherwise flags_q.
  - Latency: on accept, res_valid=1 and res_taken=eval at the next edge.
  - res_valid=0 in any cycle without an accept. res_taken holds its last value when res_valid=0.
  - A query with cond_ready=0 is not accepted; the requester holds cond_valid and cond_code.
- Condition table, N Z C V = flags:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 0.
- Back-to-back: queries may be accepted every cycle; results appear in order, one per cycle.

Decomposition:
- Shared package holds:
  - condition-code constants COND_EQ..COND_NV;
  - flag bit index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0;
  - the 4-bit flags typedef.
- One sub-module, cond_eval: purely combinational code+flags→taken, reused by the branch unit.
- Counter, epoch, flags register and handshake live in flag_cond_unit.

Test Plan:
- Reset: rst_n=0 mid-query → flags_q=0000, pend_cnt=0, res_valid=0 immediately, without waiting for a clock edge.
- Bypass: set_pend; next cycle cond_valid with EQ while the write flag_in=0100 arrives →
  - cond_ready=1 that cycle;
  - res_valid=1, res_taken=1 next cycle;
  - flags_q=0100.
- Stall: two set_pend; GE query held while the first write (1000) lands →
  - cond_ready=0;
  - second write 1001 →
    - accept in that cycle;
    - res_taken=1, since N==V.
- Flush: set_pend×3 at epoch 0, flush → pend_cnt=0, epoch=1. Late write with epoch 0, flag_in=1111 → ignored; flags unchanged; no flag_err.
- Saturation/error:
  - 8 set_pend with PEND_W=3 → pend_cnt stays 7, pend_full=1.
  - From cnt=0, a current-epoch write → flag_err pulse, flags updated.
- Table sweep: for all 16 flag values × 16 codes with cnt=0 → res_taken matches the condition table, one result per cycle.

Source files
------------

// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag consumer: flag bit positions, flag vector type
// and the 4-bit condition-code encoding used by issue and the branch unit.
package flag_cond_unit_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1,
    COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5,
    COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9,
    COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD,
    COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Purely combinational condition evaluator: code + {N,Z,C,V} -> taken.
// Kept standalone so the branch unit can instantiate the same table.
module cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [3:0] code,
  input  flags_t     flags,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    n     = flags[FLG_N];
    z     = flags[FLG_Z];
    c     = flags[FLG_C];
    v     = flags[FLG_V];
    taken = 1'b0;
    case (code)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural N/Z/C/V register with in-flight writer tracking, epoch-based
// squash of stale writes, and a stalling condition-query port with last-write bypass.
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int     PEND_W      = 3,
  parameter flags_t RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_pend,
  output logic              pend_full,
  input  logic              flag_wr_valid,
  input  logic              flag_wr_epoch,
  input  flags_t            flag_in,
  input  logic              flush,
  output logic              epoch,
  input  logic              cond_valid,
  input  logic [3:0]        cond_code,
  output logic              cond_ready,
  output logic              res_valid,
  output logic              res_taken,
  output flags_t            flags_q,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              flag_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic              wr_ok, bypass, accept, taken;
  flags_t            eval_flags;
  logic [PEND_W-1:0] cnt_nxt;

  assign wr_ok      = flag_wr_valid && (flag_wr_epoch == epoch);
  assign pend_full  = (pend_cnt == PEND_MAX);
  // Only the final outstanding writer may be forwarded; anything older is not final.
  assign bypass     = (pend_cnt == PEND_ONE) && wr_ok && !set_pend;
  assign cond_ready = !flush && ((pend_cnt == '0) || bypass);
  assign accept     = cond_valid && cond_ready;
  assign eval_flags = bypass ? flag_in : flags_q;

  cond_eval u_eval (
    .code  (cond_code),
    .flags (eval_flags),
    .taken (taken)
  );

  always_comb begin
    cnt_nxt = pend_cnt;
    if (flush)
      cnt_nxt = '0;
    else if (set_pend && !wr_ok)
      cnt_nxt = pend_full ? pend_cnt : pend_cnt + PEND_ONE;
    else if (wr_ok && !set_pend && (pend_cnt != '0))
      cnt_nxt = pend_cnt - PEND_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= RESET_FLAGS;
      pend_cnt  <= '0;
      epoch     <= 1'b0;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      if (wr_ok) flags_q <= flag_in;
      pend_cnt  <= cnt_nxt;
      if (flush) epoch <= !epoch;
      res_valid <= accept;
      if (accept) res_taken <= taken;
      // A current-epoch write nobody announced: flags still land, count stays 0.
      flag_err  <= wr_ok && (pend_cnt == '0) && !set_pend;
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed vector table for the multi-cycle corners,
// then random and exhaustive-table traffic checked against a behavioural model.
module tb_flag_cond_unit;

  localparam int PEND_W = 3;
  localparam int MAX    = (1 << PEND_W) - 1;

  logic              clk, rst_n;
  logic              set_pend, pend_full, flag_wr_valid, flag_wr_epoch, flush, epoch;
  logic [3:0]        flag_in, cond_code, flags_q;
  logic              cond_valid, cond_ready, res_valid, res_taken, flag_err;
  logic [PEND_W-1:0] pend_cnt;

  flag_cond_unit #(.PEND_W(PEND_W), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .set_pend(set_pend), .pend_full(pend_full),
    .flag_wr_valid(flag_wr_valid), .flag_wr_epoch(flag_wr_epoch), .flag_in(flag_in),
    .flush(flush), .epoch(epoch), .cond_valid(cond_valid), .cond_code(cond_code),
    .cond_ready(cond_ready), .res_valid(res_valid), .res_taken(res_taken),
    .flags_q(flags_q), .pend_cnt(pend_cnt), .flag_err(flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // model state
  logic [3:0] m_flags;
  int         m_cnt;
  logic       m_ep, m_rv, m_rt, m_err;

  typedef struct {
    logic sp, wv, we; logic [3:0] fi; logic fl, cv; logic [3:0] cc;
    logic rdy, full, rv, rt; logic [3:0] fq; int cnt; logic ep, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mv(logic sp, logic wv, logic we, logic [3:0] fi, logic fl,
                              logic cv, logic [3:0] cc, logic rdy, logic full, logic rv,
                              logic rt, logic [3:0] fq, int cnt, logic ep, logic err);
    vec_t t;
    t.sp = sp; t.wv = wv; t.we = we; t.fi = fi; t.fl = fl; t.cv = cv; t.cc = cc;
    t.rdy = rdy; t.full = full; t.rv = rv; t.rt = rt; t.fq = fq; t.cnt = cnt;
    t.ep = ep; t.err = err;
    return t;
  endfunction

  // Codes come in complementary pairs: odd code = negation of the even one.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    bit base;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sp, wv, we, input logic [3:0] fi,
                       input logic fl, cv, input logic [3:0] cc);
    set_pend = sp; flag_wr_valid = wv; flag_wr_epoch = we; flag_in = fi;
    flush = fl; cond_valid = cv; cond_code = cc;
  endtask

  function automatic logic m_ready();
    logic wok = flag_wr_valid && (flag_wr_epoch == m_ep);
    return !flush && (m_cnt == 0 || (m_cnt == 1 && wok && !set_pend));
  endfunction

  // Advance the model using the inputs currently on the pins.
  task automatic model_post();
    logic wok = flag_wr_valid && (flag_wr_epoch == m_ep);
    logic byp = (m_cnt == 1) && wok && !set_pend;
    logic acc = cond_valid && m_ready();
    m_rv  = acc;
    if (acc) m_rt = ref_cond(cond_code, byp ? flag_in : m_flags);
    m_err = wok && (m_cnt == 0) && !set_pend;
    if (wok) m_flags = flag_in;
    if (flush) m_cnt = 0;
    else if (set_pend && !wok) m_cnt = (m_cnt < MAX) ? m_cnt + 1 : MAX;
    else if (wok && !set_pend && m_cnt > 0) m_cnt = m_cnt - 1;
    if (flush) m_ep = !m_ep;
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_cnt = 0; m_ep = 0; m_rv = 0; m_rt = 0; m_err = 0;
  endtask

  task automatic step(input logic sp, wv, we, input logic [3:0] fi,
                      input logic fl, cv, input logic [3:0] cc, output logic rdy);
    drive(sp, wv, we, fi, fl, cv, cc);
    #1;
    rdy = m_ready();
    chk("cond_ready", 8'(cond_ready), 8'(rdy));
    chk("pend_full", 8'(pend_full), 8'(m_cnt == MAX));
    model_post();
    @(posedge clk); #1;
    chk("res_valid", 8'(res_valid), 8'(m_rv));
    chk("res_taken", 8'(res_taken), 8'(m_rt));
    chk("flags_q", 8'(flags_q), 8'(m_flags));
    chk("pend_cnt", 8'(pend_cnt), 8'(m_cnt));
    chk("epoch", 8'(epoch), 8'(m_ep));
    chk("flag_err", 8'(flag_err), 8'(m_err));
  endtask

  initial begin
    logic rdy, hold;

    // sp wv we fi fl cv cc | rdy full | rv rt fq cnt ep err
    tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, 1,0, 0,0,4'b0000,1,0,0));   // bypass
    tbl.push_back(mv(0,1,0,4'h4,0,1,4'h0, 1,0, 1,1,4'b0100,0,0,0));
    tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, 1,0, 0,1,4'b0100,1,0,0));   // stall
    tbl.push_back(mv(1,0,0,4'h0,0,1,4'hA, 0,0, 0,1,4'b0100,2,0,0));
    tbl.push_back(mv(0,1,0,4'h8,0,1,4'hA, 0,0, 0,1,4'b1000,1,0,0));
    tbl.push_back(mv(0,1,0,4'h9,0,1,4'hA, 1,0, 1,1,4'b1001,0,0,0));
    tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, 1,0, 0,1,4'b1001,1,0,0));   // flush
    tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, 0,0, 0,1,4'b1001,2,0,0));
    tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, 0,0, 0,1,4'b1001,3,0,0));
    tbl.push_back(mv(0,0,0,4'h0,1,0,4'h0, 0,0, 0,1,4'b1001,0,1,0));
    tbl.push_back(mv(0,1,0,4'hF,0,0,4'h0, 1,0, 0,1,4'b1001,0,1,0));   // stale write
    for (int k = 0; k < 8; k++)                                        // saturation
      tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, k == 0, k == MAX, 0,1,4'b1001,
                       (k == MAX) ? MAX : k + 1, 1, 0));
    tbl.push_back(mv(0,0,0,4'h0,1,0,4'h0, 0,1, 0,1,4'b1001,0,0,0));
    tbl.push_back(mv(0,1,0,4'h6,0,0,4'h0, 1,0, 0,1,4'b0110,0,0,1));   // error pulse
    tbl.push_back(mv(0,0,0,4'h0,0,0,4'h0, 1,0, 0,1,4'b0110,0,0,0));
    tbl.push_back(mv(1,0,0,4'h0,0,0,4'h0, 1,0, 0,1,4'b0110,1,0,0));   // write in flush cycle
    tbl.push_back(mv(1,1,0,4'h3,1,0,4'h0, 0,0, 0,1,4'b0011,0,1,0));
    tbl.push_back(mv(0,0,0,4'h0,0,1,4'hF, 1,0, 1,0,4'b0011,0,1,0));   // res_taken hold
    tbl.push_back(mv(0,0,0,4'h0,0,0,4'h0, 1,0, 0,0,4'b0011,0,1,0));
    tbl.push_back(mv(0,0,0,4'h0,0,1,4'hE, 1,0, 1,1,4'b0011,0,1,0));
    tbl.push_back(mv(0,0,0,4'h0,0,0,4'h0, 1,0, 0,1,4'b0011,0,1,0));

    rst_n = 1'b0;
    drive(0, 0, 0, 4'h0, 0, 0, 4'h0);
    model_reset();
    #2;
    chk("rst flags_q", 8'(flags_q), 8'h00);
    chk("rst pend_cnt", 8'(pend_cnt), 8'h00);
    chk("rst epoch", 8'(epoch), 8'h00);
    chk("rst res_valid", 8'(res_valid), 8'h00);
    chk("rst flag_err", 8'(flag_err), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].sp, tbl[i].wv, tbl[i].we, tbl[i].fi, tbl[i].fl, tbl[i].cv, tbl[i].cc);
      #1;
      chk($sformatf("v%0d cond_ready", i), 8'(cond_ready), 8'(tbl[i].rdy));
      chk($sformatf("v%0d pend_full", i), 8'(pend_full), 8'(tbl[i].full));
      model_post();
      @(posedge clk); #1;
      chk($sformatf("v%0d res_valid", i), 8'(res_valid), 8'(tbl[i].rv));
      chk($sformatf("v%0d res_taken", i), 8'(res_taken), 8'(tbl[i].rt));
      chk($sformatf("v%0d flags_q", i), 8'(flags_q), 8'(tbl[i].fq));
      chk($sformatf("v%0d pend_cnt", i), 8'(pend_cnt), 8'(tbl[i].cnt));
      chk($sformatf("v%0d epoch", i), 8'(epoch), 8'(tbl[i].ep));
      chk($sformatf("v%0d flag_err", i), 8'(flag_err), 8'(tbl[i].err));
    end

    // random traffic; a refused query is held until accepted
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic sp, wv, we, fl, cv;
      logic [3:0] fi, cc;
      sp = ($urandom_range(0, 2) == 0);
      wv = $urandom_range(0, 1) == 1;
      we = ($urandom_range(0, 5) == 0) ? !m_ep : m_ep;
      fi = 4'($urandom);
      fl = ($urandom_range(0, 15) == 0);
      if (!hold) begin
        cv = $urandom_range(0, 1) == 1;
        cc = 4'($urandom);
      end else begin
        cv = cond_valid;
        cc = cond_code;
      end
      step(sp, wv, we, fi, fl, cv, cc, rdy);
      hold = cv && !rdy;
    end

    // full condition table with no writers outstanding, back-to-back queries
    step(0, 0, 0, 4'h0, 1, 0, 4'h0, rdy);
    for (int f = 0; f < 16; f++) begin
      step(0, 1, m_ep, 4'(f), 0, 0, 4'h0, rdy);
      for (int c = 0; c < 16; c++) step(0, 0, 0, 4'h0, 0, 1, 4'(c), rdy);
    end

    // async reset while a result is being presented
    step(1, 0, 0, 4'h0, 0, 1, 4'hE, rdy);
    chk("pre-rst res_valid", 8'(res_valid), 8'h01);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async flags_q", 8'(flags_q), 8'h00);
    chk("async pend_cnt", 8'(pend_cnt), 8'h00);
    chk("async res_valid", 8'(res_valid), 8'h00);
    chk("async epoch", 8'(epoch), 8'h00);
    drive(0, 0, 0, 4'h0, 0, 0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 4'h0, 0, 1, 4'h0, rdy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
